// File: rtl/divider_multi.sv
// -----------------------------------------------------------------------------
// divider_multi
//
// CH-channel integer clock divider. Each channel divides clk by its own ratio
// R, produces a divided clock and a one-cycle clk-domain tick on every divided
// rising edge, and only adopts a new ratio at a period boundary, so no divided
// period is ever cut short. A global sync restarts all enabled divided
// channels so that channels with equal ratios produce identical waveforms.
//
// Modes per channel (R = ratio currently in force):
//   R = 0 or 1 : bypass, clk_out = clk gated by ch_en, tick = ch_en
//   R >= 2     : divided, low for ceil(R/2) cycles then high for floor(R/2)
//
// Optional build macro:
//   DIVIDER_MULTI_HALF_CYCLE_EN - adds a falling-edge flop per channel so odd
//   ratios (R >= 3) get an exact 50% duty cycle. Rising edges, and therefore
//   tick alignment, do not move.
//
// Ports:
//   clk        in   source clock (only clock)
//   rst        in   synchronous active-high reset
//   div_in     in   CH*CW requested ratio, channel i at [i*CW +: CW]
//   ch_en      in   CH    channel enable
//   sync       in   single-cycle restart of all enabled divided channels
//   clk_out    out  CH    divided clock per channel
//   tick       out  CH    one-cycle pulse, high in the first cycle clk_out is high
//   ratio_act  out  CH*CW ratio currently in force per channel
// -----------------------------------------------------------------------------
module divider_multi #(
    parameter int unsigned CH = 4,
    parameter int unsigned CW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CH*CW-1:0]  div_in,
    input  logic [CH-1:0]     ch_en,
    input  logic              sync,
    output logic [CH-1:0]     clk_out,
    output logic [CH-1:0]     tick,
    output logic [CH*CW-1:0]  ratio_act
);

    // Per-channel state
    logic [CW-1:0] ratio_r [CH];
    logic [CW-1:0] cnt_r   [CH];
    logic [CH-1:0] out_p;
    logic [CH-1:0] tick_r;

    // Per-channel decode of the ratio in force
    logic [CW-1:0] cnt_nxt [CH];
    logic [CW-1:0] low_len [CH];   // L = ceil(R/2)
    logic [CH-1:0] bypass;
    logic [CH-1:0] period_end;
    logic [CH-1:0] restart;
    logic [CH-1:0] div_clk;        // divided clock before bypass/enable gating

    always_comb begin
        for (int unsigned i = 0; i < CH; i++) begin
            bypass[i]     = (ratio_r[i] < CW'(2));
            period_end[i] = (cnt_r[i] == ratio_r[i] - CW'(1));
            // Computed as floor(R/2) + lsb so R = 2^CW-1 cannot overflow.
            low_len[i]    = (ratio_r[i] >> 1) + {{(CW-1){1'b0}}, ratio_r[i][0]};
            cnt_nxt[i]    = period_end[i] ? '0 : cnt_r[i] + CW'(1);
            // Disabled, bypass and sync all collapse to the same action:
            // clear the counter and output, and load a fresh ratio.
            restart[i]    = !ch_en[i] || bypass[i] || sync;
            ratio_act[i*CW +: CW] = ratio_r[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < CH; i++) begin
                ratio_r[i] <= '0;
                cnt_r[i]   <= '0;
            end
            out_p  <= '0;
            tick_r <= '0;
        end else begin
            for (int unsigned i = 0; i < CH; i++) begin
                if (restart[i]) begin
                    cnt_r[i]   <= '0;
                    out_p[i]   <= 1'b0;
                    tick_r[i]  <= 1'b0;
                    ratio_r[i] <= div_in[i*CW +: CW];
                end else begin
                    cnt_r[i]  <= cnt_nxt[i];
                    // Registered from the next count so out_p tracks cnt >= L
                    // and tick marks the cycle with cnt == L.
                    out_p[i]  <= (cnt_nxt[i] >= low_len[i]);
                    tick_r[i] <= (cnt_nxt[i] == low_len[i]);
                    if (period_end[i]) begin
                        ratio_r[i] <= div_in[i*CW +: CW];
                    end
                end
            end
        end
    end

`ifdef DIVIDER_MULTI_HALF_CYCLE_EN
    // Falling-edge copy of out_p stretches the high phase by half a cycle.
    logic [CH-1:0] out_n;

    always_ff @(negedge clk) begin
        if (rst) begin
            out_n <= '0;
        end else begin
            for (int unsigned i = 0; i < CH; i++) begin
                out_n[i] <= ch_en[i] ? out_p[i] : 1'b0;
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < CH; i++) begin
            // Odd and not bypass implies R >= 3.
            div_clk[i] = (ratio_r[i][0] && !bypass[i]) ? (out_p[i] | out_n[i])
                                                       : out_p[i];
        end
    end
`else
    always_comb begin
        div_clk = out_p;
    end
`endif

    // Output gating: reset and disable force both outputs low immediately;
    // bypass passes the source clock straight through.
    always_comb begin
        for (int unsigned i = 0; i < CH; i++) begin
            if (rst || !ch_en[i]) begin
                clk_out[i] = 1'b0;
                tick[i]    = 1'b0;
            end else if (bypass[i]) begin
                clk_out[i] = clk;
                tick[i]    = 1'b1;
            end else begin
                clk_out[i] = div_clk[i];
                tick[i]    = tick_r[i];
            end
        end
    end

endmodule
